dcache_controller: RTL and testbench

//  Direct-mapped, write-back, write-allocate L1 data cache between the CPU MEM stage and off-chip data memory.
//  MEM stage issues one word load/store per cycle. Hits complete in the same cycle.

---
 rtl/dcache_pkg.sv | 29 ++
 rtl/dcache_sram.sv | 49 ++++
 rtl/dcache_controller.sv | 180 ++++++++++++++++++
 tb/tb_dcache_controller.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types, geometry and address-field helpers for the L1 data cache.
package dcache_pkg;

  localparam int NUM_LINES = 32;
  localparam int LINE_BITS = 256;
  localparam int IDX_W     = $clog2(NUM_LINES);
  localparam int OFF_W     = 5;
  localparam int TAG_W     = 32 - IDX_W - OFF_W;
  localparam int WSEL_W    = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [WSEL_W-1:0] addr_word(input logic [31:0] a);
    return a[OFF_W-1:2];
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: asynchronous read, one synchronous write port.
// Valid and dirty clear on reset; tag and data are left uninitialised.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output logic [TAG_W-1:0]     rd_tag_o,
  output logic                 rd_valid_o,
  output logic                 rd_dirty_o,
  output logic [LINE_BITS-1:0] rd_data_o,
  input  logic                 wr_en_i,
  input  logic [IDX_W-1:0]     wr_idx_i,
  input  logic [TAG_W-1:0]     wr_tag_i,
  input  logic [LINE_BITS-1:0] wr_data_i,
  input  logic                 wr_dirty_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  // Line status bits; any write makes the line valid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

  // Tag and line payload storage.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 data cache controller.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  state_e state_q, state_d;

  // Miss address is latched so a pipeline flush cannot disturb the refill.
  logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0] miss_idx_q, miss_idx_d;

  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     req_idx;
  logic [WSEL_W-1:0]    req_word;
  logic [IDX_W-1:0]     rd_idx;
  logic [TAG_W-1:0]     rd_tag;
  logic                 rd_valid;
  logic                 rd_dirty;
  logic [LINE_BITS-1:0] rd_data;
  logic [LINE_BITS-1:0] merged;
  logic                 hit;
  logic                 idle_hit;
  logic                 miss_start;

  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  logic [TAG_W-1:0]     wr_tag;
  logic [LINE_BITS-1:0] wr_data;
  logic                 wr_dirty;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_addr_i[1:0];

  assign req_tag  = addr_tag(cpu_addr_i);
  assign req_idx  = addr_idx(cpu_addr_i);
  assign req_word = addr_word(cpu_addr_i);

  // Lookups use the live CPU index; refill/writeback use the latched miss index.
  assign rd_idx = (state_q == IDLE) ? req_idx : miss_idx_q;

  dcache_sram u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (rd_idx),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_data_o  (rd_data),
    .wr_en_i    (wr_en),
    .wr_idx_i   (wr_idx),
    .wr_tag_i   (wr_tag),
    .wr_data_i  (wr_data),
    .wr_dirty_i (wr_dirty)
  );

  assign hit      = cpu_req_i & rd_valid & (rd_tag == req_tag);
  assign idle_hit = (state_q == IDLE) & hit;

  // Stall is gated by reset so the pipeline is released the moment reset asserts.
  assign cpu_stall_o = rst_i & cpu_req_i & ~idle_hit;
  assign cpu_data_o  = (idle_hit & ~cpu_we_i) ? rd_data[{req_word, 5'b0} +: 32] : 32'h0;

  // Store-hit word merge into the current line.
  always_comb begin
    merged = rd_data;
    merged[{req_word, 5'b0} +: 32] = cpu_data_i;
  end

  // State and latched miss address.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
    end
  end

  // Next state, memory port drive and storage write selection.
  always_comb begin
    state_d    = state_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    miss_start = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = 32'h0;
    mem_data_o = '0;
    wr_en      = 1'b0;
    wr_idx     = req_idx;
    wr_tag     = req_tag;
    wr_data    = merged;
    wr_dirty   = 1'b1;
    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          if (hit) begin
            wr_en = cpu_we_i;
          end else begin
            miss_start = 1'b1;
            miss_tag_d = req_tag;
            miss_idx_d = req_idx;
            state_d    = (rd_valid & rd_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {rd_tag, miss_idx_q, {OFF_W{1'b0}}};
        mem_data_o = rd_data;
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          wr_en    = 1'b1;
          wr_idx   = miss_idx_q;
          wr_tag   = miss_tag_q;
          wr_data  = mem_data_i;
          wr_dirty = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        retry_q;
  logic        done;

  assign done = cpu_req_i & ~cpu_stall_o;

  // retry_q marks an access whose first lookup missed, so its retried hit is not counted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      retry_q    <= 1'b0;
    end else begin
      if (miss_start) retry_q <= 1'b1;
      else if (state_q == IDLE && (done || !cpu_req_i)) retry_q <= 1'b0;
      if (done && !retry_q && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_start && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Testbench for dcache_controller: directed vector table, hand-written corner
// sequences, then randomized accesses against a behavioural cache/memory model.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  dcache_controller dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         exp_miss;
    logic         exp_wb;
    logic [31:0]  wb_addr;
    logic [255:0] wb_line;
    logic [31:0]  alloc_addr;
    logic [255:0] refill;
    logic [31:0]  exp_rdata;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: cache contents and backing memory, kept as plain arrays.
  logic         mv   [32];
  logic         md   [32];
  logic [21:0]  mt   [32];
  logic [255:0] mdat [32];
  logic [255:0] mem_model [logic [31:0]];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [255:0] line_of(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  function automatic vec_t mkv(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic miss, input logic wb, input logic [31:0] wb_addr,
                               input logic [255:0] wb_line, input logic [31:0] alloc_addr,
                               input logic [255:0] refill, input logic [31:0] rdata);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.exp_miss = miss; v.exp_wb = wb;
    v.wb_addr = wb_addr; v.wb_line = wb_line; v.alloc_addr = alloc_addr;
    v.refill = refill; v.exp_rdata = rdata;
    return v;
  endfunction

  // One memory transaction: check the request, hold it a random while, then ack.
  task automatic mem_phase(input logic exp_we, input logic [31:0] exp_addr, input logic chk_line,
                           input logic [255:0] exp_line, input logic [255:0] resp);
    int d;
    @(negedge clk_i);
    chk("mem_req", mem_req_o, 1'b1);
    chk("mem_we", mem_we_o, exp_we);
    chk("mem_addr", mem_addr_o, exp_addr);
    if (chk_line) chk("mem_data_o", mem_data_o, exp_line);
    d = $urandom_range(0, 2);
    for (int k = 0; k < d; k++) begin
      @(negedge clk_i);
      chk("mem_addr_hold", mem_addr_o, exp_addr);
    end
    mem_ack_i  = 1'b1;
    mem_data_i = resp;
    @(posedge clk_i);
    #1;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
  endtask

  // Full CPU access; starts and ends 1 time unit after a rising edge.
  task automatic run_access(input vec_t v);
    cpu_req_i  = 1'b1;
    cpu_we_i   = v.we;
    cpu_addr_i = v.addr;
    cpu_data_i = v.wdata;
    @(negedge clk_i);
    chk("first_stall", cpu_stall_o, v.exp_miss);
    chk("first_mem_req", mem_req_o, 1'b0);
    if (v.exp_miss) begin
      @(posedge clk_i);
      #1;
      if (v.exp_wb) mem_phase(1'b1, v.wb_addr, 1'b1, v.wb_line, '0);
      mem_phase(1'b0, v.alloc_addr, 1'b0, '0, v.refill);
      @(negedge clk_i);
      chk("retry_stall", cpu_stall_o, 1'b0);
      chk("retry_mem_req", mem_req_o, 1'b0);
    end
    if (!v.we) chk("load_data", cpu_data_o, v.exp_rdata);
    @(posedge clk_i);
    #1;
    cpu_req_i = 1'b0;
  endtask

  // Build a random access and its expectations from the model, then advance the model.
  task automatic rand_vec(output vec_t v);
    logic [31:0]  a;
    logic [4:0]   idx;
    logic [21:0]  tag;
    logic [2:0]   w;
    logic [255:0] l;
    a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5)
      | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
    v = '0;
    v.we = 1'($urandom_range(0, 1));
    v.addr = a;
    v.wdata = $urandom;
    idx = a[9:5];
    tag = a[31:10];
    w = a[4:2];
    v.exp_miss = !(mv[idx] && mt[idx] == tag);
    if (v.exp_miss) begin
      v.exp_wb = mv[idx] && md[idx];
      v.wb_addr = {mt[idx], idx, 5'b0};
      v.wb_line = mdat[idx];
      v.alloc_addr = {a[31:5], 5'b0};
      if (!mem_model.exists(v.alloc_addr))
        mem_model[v.alloc_addr] = {$urandom, $urandom, $urandom, $urandom,
                                   $urandom, $urandom, $urandom, $urandom};
      v.refill = mem_model[v.alloc_addr];
      if (v.exp_wb) mem_model[v.wb_addr] = mdat[idx];
      mdat[idx] = v.refill;
      mt[idx] = tag;
      mv[idx] = 1'b1;
      md[idx] = 1'b0;
    end
    l = mdat[idx];
    if (v.we) begin
      l[{w, 5'b0} +: 32] = v.wdata;
      mdat[idx] = l;
      md[idx] = 1'b1;
    end else begin
      v.exp_rdata = l[{w, 5'b0} +: 32];
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    cpu_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t dir_tab [9];
    vec_t post_tab [2];
    vec_t v;
    logic [255:0] line_a, line_b, line_c, line_d, line_e, wb_a, wb_c;

    line_a = line_of(32'hA000_0000);
    line_a[95:64] = 32'hDEAD_BEEF;
    line_b = line_of(32'hB000_0000);
    line_c = line_of(32'hC000_0000);
    line_d = line_of(32'hD000_0000);
    line_e = line_of(32'hE000_0000);
    wb_a = line_a;
    wb_a[31:0] = 32'h1234_5678;
    wb_c = line_c;
    wb_c[31:0] = 32'hCAFE_F00D;

    dir_tab[0] = mkv(0, 32'h40,   0,             1, 0, 0,     0,    32'h40,   line_a, 32'hA000_0000);
    dir_tab[1] = mkv(0, 32'h48,   0,             0, 0, 0,     0,    0,        0,      32'hDEAD_BEEF);
    dir_tab[2] = mkv(1, 32'h40,   32'h1234_5678, 0, 0, 0,     0,    0,        0,      0);
    dir_tab[3] = mkv(0, 32'h40,   0,             0, 0, 0,     0,    0,        0,      32'h1234_5678);
    dir_tab[4] = mkv(0, 32'h440,  0,             1, 1, 32'h40, wb_a, 32'h440, line_b, 32'hB000_0000);
    dir_tab[5] = mkv(1, 32'h80,   32'hCAFE_F00D, 1, 0, 0,     0,    32'h80,   line_c, 0);
    dir_tab[6] = mkv(0, 32'h84,   0,             0, 0, 0,     0,    0,        0,      32'hC000_0001);
    dir_tab[7] = mkv(0, 32'h80,   0,             0, 0, 0,     0,    0,        0,      32'hCAFE_F00D);
    dir_tab[8] = mkv(0, 32'h1080, 0,             1, 1, 32'h80, wb_c, 32'h1080, line_d, 32'hD000_0000);
    post_tab[0] = mkv(0, 32'h100, 0,             1, 0, 0,     0,    32'h100,  line_e, 32'hE000_0000);
    post_tab[1] = mkv(0, 32'h48,  0,             1, 0, 0,     0,    32'h40,   line_a, 32'hDEAD_BEEF);

    rst_i = 1'b0;
    cpu_req_i = 1'b1;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h40;
    cpu_data_i = '0;
    mem_data_i = '0;
    mem_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_stall", cpu_stall_o, 1'b0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_we", mem_we_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_data", mem_data_o, '0);
    chk("rst_cpu_data", cpu_data_o, 32'h0);
`ifdef DCACHE_STATS_EN
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif
    cpu_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_access(dir_tab[i]);
`ifdef DCACHE_STATS_EN
      if (i == 4) begin
        chk("stats_hit_cnt", hit_cnt, 32'd3);
        chk("stats_miss_cnt", miss_cnt, 32'd2);
      end
`endif
    end

    // Flush during refill: request drops, refill still completes and installs.
    cpu_req_i = 1'b1;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h300;
    @(negedge clk_i);
    chk("flush_stall", cpu_stall_o, 1'b1);
    @(posedge clk_i);
    #1;
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    chk("flush_mem_req", mem_req_o, 1'b1);
    chk("flush_mem_addr", mem_addr_o, 32'h300);
    mem_ack_i = 1'b1;
    mem_data_i = line_d;
    @(posedge clk_i);
    #1;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    @(negedge clk_i);
    chk("flush_done_req", mem_req_o, 1'b0);

    // Stray ack in IDLE must not start or alter anything.
    mem_ack_i = 1'b1;
    mem_data_i = line_e;
    @(posedge clk_i);
    #1;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    @(negedge clk_i);
    chk("idle_ack_req", mem_req_o, 1'b0);
    @(posedge clk_i);
    #1;
    run_access(mkv(0, 32'h304, 0, 0, 0, 0, 0, 0, 0, 32'hD000_0001));

    // Reset in the middle of a refill.
    cpu_req_i = 1'b1;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h100;
    @(negedge clk_i);
    chk("rstmid_first_stall", cpu_stall_o, 1'b1);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("rstmid_alloc_req", mem_req_o, 1'b1);
    chk("rstmid_alloc_addr", mem_addr_o, 32'h100);
    rst_i = 1'b0;
    #1;
    chk("rstmid_req_drop", mem_req_o, 1'b0);
    chk("rstmid_stall_drop", cpu_stall_o, 1'b0);
    @(posedge clk_i);
    #1;
    cpu_req_i = 1'b0;
    rst_i = 1'b1;
    for (int i = 0; i < 2; i++) run_access(post_tab[i]);

    // Randomized accesses against the model from a clean reset.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      rand_vec(v);
      run_access(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
